// File: rtl/tawas_pkg.sv
// Shared Tawas types and widths.
// Used by the PC stack and its per-slice LIFO.
package tawas_pkg;

  localparam int TAWAS_PC_W   = 24;
  localparam int TAWAS_SLICES = 4;

  typedef logic [1:0]            slice_t;
  typedef logic [TAWAS_PC_W-1:0] pc_t;

endpackage

// File: rtl/tawas_pc_lifo.sv
// One slice's return-address LIFO.
// Error detection enabled by TAWAS_PC_STACK_ERR_EN.
module tawas_pc_lifo
  import tawas_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  pc_t  din,
  output pc_t  top,
  output logic empty,
  output logic full,
  output logic err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  pc_t           mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW:0]   count;
  logic          err_q;

  logic [AW-1:0] wp_dec;
  logic          we;
  logic [AW-1:0] waddr;

  assign wp_dec = wp - 1'b1;
  assign empty  = (count == '0);
  assign full   = (count == CNT_MAX);
  assign top    = empty ? '0 : mem[wp_dec];

`ifdef TAWAS_PC_STACK_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    we    = 1'b0;
    waddr = wp;
    if (!rst && !flush && push) begin
      if (pop && !empty) begin
        we    = 1'b1;
        waddr = wp_dec;
      end else begin
`ifdef TAWAS_PC_STACK_ERR_EN
        we = pop || !full;
`else
        we = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else if (push && pop) begin
      // replace-top keeps pointer; on empty it is a plain push
      if (empty) begin
        wp    <= wp + 1'b1;
        count <= count + 1'b1;
      end
    end else if (push) begin
`ifdef TAWAS_PC_STACK_ERR_EN
      if (full) begin
        err_q <= 1'b1;
      end else begin
        wp    <= wp + 1'b1;
        count <= count + 1'b1;
      end
`else
      wp <= wp + 1'b1;
      if (!full) count <= count + 1'b1;
`endif
    end else if (pop) begin
      if (!empty) begin
        wp    <= wp_dec;
        count <= count - 1'b1;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tawas_pc_stack.sv
// Per-slice hardware return-address stack.
// Optional error detection: TAWAS_PC_STACK_ERR_EN.
module tawas_pc_stack
  import tawas_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              slice,
  input  logic                    pc_store,
  input  logic [TAWAS_PC_W-1:0]   pc_out,
  input  logic                    pc_restore,
  output logic [TAWAS_PC_W-1:0]   pc_rtn,
  input  logic [TAWAS_SLICES-1:0] flush,
  output logic [TAWAS_SLICES-1:0] stack_empty,
  output logic [TAWAS_SLICES-1:0] stack_full,
  output logic [TAWAS_SLICES-1:0] stack_err
);

  logic [TAWAS_SLICES-1:0] push_v;
  logic [TAWAS_SLICES-1:0] pop_v;
  pc_t                     tops [TAWAS_SLICES];

  for (genvar i = 0; i < TAWAS_SLICES; i++) begin : g_slice
    assign push_v[i] = pc_store   && (slice == slice_t'(i));
    assign pop_v[i]  = pc_restore && (slice == slice_t'(i));

    tawas_pc_lifo #(
      .DEPTH (DEPTH)
    ) u_lifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_v[i]),
      .pop   (pop_v[i]),
      .flush (flush[i]),
      .din   (pc_out),
      .top   (tops[i]),
      .empty (stack_empty[i]),
      .full  (stack_full[i]),
      .err   (stack_err[i])
    );
  end

  assign pc_rtn = tops[slice];

endmodule

// File: tb/tb_tawas_pc_stack.sv
// Scoreboard bench for tawas_pc_stack.
// Expected tops are queued at push time and popped on readback.
module tb_tawas_pc_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  slice;
  logic        pc_store;
  logic [23:0] pc_out;
  logic        pc_restore;
  logic [23:0] pc_rtn;
  logic [3:0]  flush;
  logic [3:0]  stack_empty;
  logic [3:0]  stack_full;
  logic [3:0]  stack_err;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q [$];
  logic [23:0] e;

`ifdef TAWAS_PC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  tawas_pc_stack #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .slice       (slice),
    .pc_store    (pc_store),
    .pc_out      (pc_out),
    .pc_restore  (pc_restore),
    .pc_rtn      (pc_rtn),
    .flush       (flush),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    pc_store   = 1'b0;
    pc_restore = 1'b0;
    flush      = 4'h0;
  endtask

  task automatic push(input int s, input logic [23:0] v);
    slice    = 2'(s);
    pc_out   = v;
    pc_store = 1'b1;
    tick();
  endtask

  task automatic pop(input int s);
    slice      = 2'(s);
    pc_restore = 1'b1;
    tick();
  endtask

  task automatic look(input int s);
    slice = 2'(s);
    #1;
  endtask

  task automatic chk_rtn(input string nm, input logic [23:0] ex);
    checks++;
    if (pc_rtn !== ex) begin
      errors++;
      $display("FAIL %s: pc_rtn=%h expected %h", nm, pc_rtn, ex);
    end
  endtask

  task automatic chk_bit(input string nm, input logic a, input logic ex);
    checks++;
    if (a !== ex) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, a, ex);
    end
  endtask

  // drain queued expectations on slice s, popping after each read
  task automatic drain(input int s, input string nm);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      look(s);
      chk_rtn(nm, e);
      pop(s);
    end
    look(s);
    chk_rtn({nm, "_empty"}, 24'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    slice = 2'd0;
    pc_store = 1'b0;
    pc_restore = 1'b0;
    pc_out = '0;
    flush = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      look(s);
      chk_rtn($sformatf("reset_rtn%0d", s), 24'd0);
    end
    checks++;
    if (stack_empty !== 4'hf || stack_full !== 4'h0 ||
        stack_err !== 4'h0) begin
      errors++;
      $display("FAIL reset_flags: e=%h f=%h r=%h expected f 0 0",
               stack_empty, stack_full, stack_err);
    end
  endtask

  task automatic test_lifo_order;
    push(1, 24'h000100);
    push(1, 24'h000200);
    exp_q.push_back(24'h000200);
    exp_q.push_back(24'h000100);
    for (int s = 0; s < 4; s += 2) begin
      look(s);
      chk_rtn($sformatf("lifo_other%0d", s), 24'd0);
    end
    look(3);
    chk_rtn("lifo_other3", 24'd0);
    chk_bit("lifo_nonempty", stack_empty[1], 1'b0);
    drain(1, "lifo_order");
    chk_bit("lifo_empty_flag", stack_empty[1], 1'b1);
  endtask

  task automatic test_overflow;
    for (int v = 1; v <= 9; v++) push(2, 24'(v));
    chk_bit("ovf_full", stack_full[2], 1'b1);
    chk_bit("ovf_err", stack_err[2], ERR_EN);
    for (int v = 8; v >= 1; v--)
      exp_q.push_back(ERR_EN ? 24'(v) : 24'(v + 1));
    drain(2, "ovf_order");
    chk_bit("ovf_not_full", stack_full[2], 1'b0);
  endtask

  task automatic test_underflow;
    pop(3);
    look(3);
    chk_rtn("udf_rtn", 24'd0);
    chk_bit("udf_empty", stack_empty[3], 1'b1);
    chk_bit("udf_err", stack_err[3], ERR_EN);
    push(3, 24'h000033);
    look(3);
    chk_rtn("udf_then_push", 24'h000033);
    pop(3);
  endtask

  task automatic test_replace;
    push(0, 24'h001111);
    push(0, 24'h00AAAA);
    look(0);
    chk_rtn("rep_before", 24'h00AAAA);
    slice = 2'd0;
    pc_out = 24'h00BBBB;
    pc_store = 1'b1;
    pc_restore = 1'b1;
    tick();
    exp_q.push_back(24'h00BBBB);
    exp_q.push_back(24'h001111);
    drain(0, "rep_order");
    chk_bit("rep_no_err", stack_err[0], 1'b0);
    slice = 2'd0;
    pc_out = 24'h00CCCC;
    pc_store = 1'b1;
    pc_restore = 1'b1;
    tick();
    look(0);
    chk_rtn("rep_on_empty", 24'h00CCCC);
    chk_bit("rep_on_empty_err", stack_err[0], 1'b0);
  endtask

  task automatic test_flush;
    push(2, 24'h000777);
    pop(1);
    chk_bit("fl_pre_err", stack_err[1], ERR_EN);
    push(1, 24'h000300);
    slice = 2'd1;
    pc_out = 24'h000400;
    pc_store = 1'b1;
    flush = 4'b0010;
    tick();
    look(1);
    chk_rtn("fl_rtn1", 24'd0);
    chk_bit("fl_empty1", stack_empty[1], 1'b1);
    chk_bit("fl_err1", stack_err[1], 1'b0);
    look(0);
    chk_rtn("fl_keep0", 24'h00CCCC);
    look(2);
    chk_rtn("fl_keep2", 24'h000777);
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++)
        push(s, 24'h100000 + 24'(r * 16 + s));
    for (int s = 0; s < 4; s++) begin
      look(s);
      chk_rtn($sformatf("b2b_top%0d", s), 24'h100010 + 24'(s));
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    slice = 2'd2;
    pc_out = 24'h00DEAD;
    pc_store = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      look(s);
      chk_rtn($sformatf("rst_mid%0d", s), 24'd0);
    end
    checks++;
    if (stack_empty !== 4'hf || stack_err !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_flags: e=%h r=%h expected f 0",
               stack_empty, stack_err);
    end
  endtask

  initial begin
    test_reset();
    test_lifo_order();
    test_overflow();
    test_underflow();
    test_replace();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
